// File: rtl/recwind_pkg.sv
// Shared types and constants for the receive-window controller.
package recwind_pkg;

  localparam int WIN_W = 16;
  localparam logic [WIN_W-1:0] WIN_RESET = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } pkt_state_t;

  function automatic logic [WIN_W-1:0] min_win(input logic [WIN_W-1:0] a,
                                               input logic [WIN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WIN_W-1:0] max_win(input logic [WIN_W-1:0] a,
                                               input logic [WIN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/recwind_window_ctrl_ewma.sv
// Sample-period counter and exponentially weighted average of queue occupancy.
module recwind_ewma #(
  parameter int OCC_WIDTH   = 12,
  parameter int SAMPLE_BITS = 10,
  parameter int EWMA_SHIFT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [OCC_WIDTH-1:0] occupancy,
  output logic                 sample,
  output logic [OCC_WIDTH-1:0] avg
);

  localparam int ACC_W = OCC_WIDTH + EWMA_SHIFT;

  logic [SAMPLE_BITS-1:0] cnt;
  logic [ACC_W-1:0]       acc;

  assign sample = &cnt;
  assign avg    = OCC_WIDTH'(acc >> EWMA_SHIFT);

  // acc settles at most at occupancy << EWMA_SHIFT, so ACC_W bits never wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (clear)
        acc <= '0;
      else if (sample)
        acc <= acc - (acc >> EWMA_SHIFT) + {{EWMA_SHIFT{1'b0}}, occupancy};
    end
  end

endmodule

// File: rtl/recwind_window_ctrl.sv
// AIMD receive-window controller; new windows reach the modifier only between packets.
//   state | meaning
//   IDLE  | between packets, window updates may be applied
//   HDR   | leading ctrl words of a packet accepted
//   BODY  | payload in flight, waiting for the EOP ctrl word
module recwind_window_ctrl
  import recwind_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int OCC_WIDTH   = 12,
  parameter int SAMPLE_BITS = 10,
  parameter int EWMA_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  input  logic                  in_rdy,
  input  logic [OCC_WIDTH-1:0]  oq_occupancy,
  input  logic                  cfg_enable,
  input  logic [WIN_W-1:0]      cfg_win_max,
  input  logic [WIN_W-1:0]      cfg_win_min,
  input  logic [WIN_W-1:0]      cfg_step,
  input  logic [OCC_WIDTH-1:0]  cfg_thresh_hi,
  input  logic [OCC_WIDTH-1:0]  cfg_thresh_lo,
  output logic [WIN_W-1:0]      win_value,
  output logic                  win_enable,
  output logic                  win_update
);

  logic                 sample;
  logic                 sample_q;
  logic [OCC_WIDTH-1:0] avg;
  pkt_state_t           state;
  logic [WIN_W-1:0]     target;
  logic [WIN_W-1:0]     target_nxt;
  logic                 pending;
  logic [WIN_W-1:0]     wmax;
  logic [WIN_W-1:0]     wmin;
  logic [WIN_W:0]       inc_sum;
  logic [WIN_W-1:0]     inc_sat;
  logic                 accept;
  logic                 ctrl_nz;
  logic                 idle_gap;
  logic                 apply;
  logic                 pending_set;

  recwind_ewma #(
    .OCC_WIDTH  (OCC_WIDTH),
    .SAMPLE_BITS(SAMPLE_BITS),
    .EWMA_SHIFT (EWMA_SHIFT)
  ) u_ewma (
    .clk      (clk),
    .reset    (reset),
    .clear    (!cfg_enable),
    .occupancy(oq_occupancy),
    .sample   (sample),
    .avg      (avg)
  );

  assign wmax    = cfg_win_max;
  assign wmin    = min_win(cfg_win_min, cfg_win_max);
  assign inc_sum = {1'b0, target} + {1'b0, cfg_step};
  assign inc_sat = inc_sum[WIN_W] ? '1 : inc_sum[WIN_W-1:0];

  always_comb begin
    target_nxt = target;
    if (!cfg_enable)
      target_nxt = wmax;
    else if (sample_q) begin
      if (avg >= cfg_thresh_hi)
        target_nxt = max_win(target >> 1, wmin);
      else if (avg <= cfg_thresh_lo)
        target_nxt = min_win(inc_sat, wmax);
    end
  end

  assign accept   = in_wr && in_rdy;
  assign ctrl_nz  = |in_ctrl;
  assign idle_gap = (state == IDLE) && !accept;
  assign apply    = idle_gap && pending;

  // While disabled, keep re-arming until the published window equals wmax;
  // an apply in flight already writes target, which tracks wmax.
  assign pending_set = (target_nxt != target) ||
                       (!cfg_enable && (win_value != wmax) && !apply);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    state <= ctrl_nz ? HDR : BODY;
        HDR:     if (!ctrl_nz) state <= BODY;
        BODY:    if (ctrl_nz) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= 1'b0;
      target     <= WIN_RESET;
      pending    <= 1'b0;
      win_value  <= WIN_RESET;
      win_enable <= 1'b0;
      win_update <= 1'b0;
    end else begin
      sample_q   <= sample;
      target     <= target_nxt;
      pending    <= pending_set || (pending && !apply);
      win_update <= apply;
      if (apply)
        win_value <= target;
      if (idle_gap)
        win_enable <= cfg_enable;
    end
  end

endmodule

// File: tb/tb_recwind_window_ctrl.sv
// Directed scoreboard bench for recwind_window_ctrl: expected window updates are queued by stimulus and checked by a monitor.
module tb_recwind_window_ctrl;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int OW = 12;
  localparam int SB = 6;
  localparam int ES = 3;
  localparam int PERIOD = 1 << SB;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [OW-1:0] oq_occupancy;
  logic          cfg_enable;
  logic [15:0]   cfg_win_max;
  logic [15:0]   cfg_win_min;
  logic [15:0]   cfg_step;
  logic [OW-1:0] cfg_thresh_hi;
  logic [OW-1:0] cfg_thresh_lo;
  logic [15:0]   win_value;
  logic          win_enable;
  logic          win_update;

  typedef struct packed {
    logic [15:0] val;
    logic        en;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            pulse_cnt = 0;
  int            last_pulse_cyc = -1;
  logic [SB-1:0] cnt_m = '0;

  recwind_window_ctrl #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .OCC_WIDTH  (OW),
    .SAMPLE_BITS(SB),
    .EWMA_SHIFT (ES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .oq_occupancy (oq_occupancy),
    .cfg_enable   (cfg_enable),
    .cfg_win_max  (cfg_win_max),
    .cfg_win_min  (cfg_win_min),
    .cfg_step     (cfg_step),
    .cfg_thresh_hi(cfg_thresh_hi),
    .cfg_thresh_lo(cfg_thresh_lo),
    .win_value    (win_value),
    .win_enable   (win_enable),
    .win_update   (win_update)
  );

  always #5 clk = ~clk;

  // bench copy of the sample-period phase, used only to line stimulus up with samples
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) cnt_m <= '0;
    else       cnt_m <= cnt_m + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && win_update === 1'b1) begin : mon
      exp_t e;
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_update: got win_value %0h at cycle %0d, expected no update", win_value, cyc);
      end else begin
        e = exp_q.pop_front();
        check("update_value", 32'(win_value), 32'(e.val));
        check("update_enable", 32'(win_enable), 32'(e.en));
      end
    end
  end

  task automatic expect_upd(input logic [15:0] v, input logic e);
    exp_t x;
    x.val = v;
    x.en  = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_cnt(input logic [SB-1:0] v);
    do @(negedge clk); while (cnt_m !== v);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d updates outstanding after %0d cycles, expected 0", name, exp_q.size(), max_cyc);
      exp_q.delete();
    end
  endtask

  task automatic word(input logic [CW-1:0] c);
    in_wr   = 1'b1;
    in_rdy  = 1'b1;
    in_ctrl = c;
    @(negedge clk);
  endtask

  // header word ctrl!=0, body ctrl==0, EOP ctrl!=0; optionally flips cfg_enable at word flip_at
  task automatic send_pkt(input int n, input int flip_at, input logic flip_val, output int eop_cyc);
    eop_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (i == flip_at) cfg_enable = flip_val;
      if (i == n - 1) eop_cyc = cyc;
      word((i == 0) ? 8'hFF : (i == n - 1) ? 8'h01 : 8'h00);
    end
    in_wr   = 1'b0;
    in_ctrl = '0;
  endtask

  initial begin
    int eop;
    int gap;
    int p0;
    reset         = 1'b1;
    in_wr         = 1'b0;
    in_rdy        = 1'b1;
    in_ctrl       = '0;
    oq_occupancy  = '0;
    cfg_enable    = 1'b1;
    cfg_win_max   = 16'h4000;
    cfg_win_min   = 16'h0400;
    cfg_step      = 16'h0100;
    cfg_thresh_hi = 12'd800;
    cfg_thresh_lo = 12'd100;
    repeat (3) @(negedge clk);
    check("reset_win_value", 32'(win_value), 32'hFFFF);
    check("reset_win_enable", 32'(win_enable), 32'h0);
    check("reset_win_update", 32'(win_update), 32'h0);

    // first sample sees avg 0 and pulls the reset target down to wmax
    expect_upd(16'h4000, 1'b1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("enable_before_sample", 32'(win_enable), 32'h1);
    check("value_before_sample", 32'(win_value), 32'hFFFF);
    drain("first_apply", 3 * PERIOD);

    // congestion: avg crosses 800 on the 13th sample, then halve down to wmin
    oq_occupancy = 12'd1000;
    expect_upd(16'h2000, 1'b1);
    expect_upd(16'h1000, 1'b1);
    expect_upd(16'h0800, 1'b1);
    expect_upd(16'h0400, 1'b1);
    drain("aimd_decrease", 40 * PERIOD);
    repeat (3 * PERIOD) @(negedge clk);
    check("decrease_floor", 32'(win_value), 32'h0400);

    // relief: additive increase until wmax
    oq_occupancy = '0;
    for (int v = 16'h0500; v <= 16'h4000; v += 16'h0100)
      expect_upd(16'(v), 1'b1);
    drain("aimd_increase", 130 * PERIOD);
    repeat (3 * PERIOD) @(negedge clk);
    check("increase_ceiling", 32'(win_value), 32'h4000);

    // quiet config: step 0 and unreachable hi keep the target still
    cfg_thresh_hi = 12'd4095;
    cfg_step      = 16'h0000;

    // one forced halving while a 10-word packet spans the sample
    wait_cnt(SB'(55));
    cfg_thresh_hi = 12'd0;
    p0 = pulse_cnt;
    expect_upd(16'h2000, 1'b1);
    wait_cnt(SB'(60));
    send_pkt(10, -1, 1'b0, eop);
    check("no_update_in_packet", 32'(pulse_cnt), 32'(p0));
    cfg_thresh_hi = 12'd4095;
    drain("deferred_apply", 20);
    @(negedge clk);
    check("deferred_apply_cycle", 32'(last_pulse_cyc), 32'(eop + 2));

    // one increase while back-to-back packets stream, then a single stalled idle cycle
    wait_cnt(SB'(55));
    cfg_step = 16'h0100;
    p0 = pulse_cnt;
    expect_upd(16'h2100, 1'b1);
    wait_cnt(SB'(60));
    send_pkt(4, -1, 1'b0, eop);
    send_pkt(4, -1, 1'b0, eop);
    send_pkt(4, -1, 1'b0, eop);
    check("no_update_back_to_back", 32'(pulse_cnt), 32'(p0));
    in_wr   = 1'b1;
    in_rdy  = 1'b0;
    in_ctrl = 8'hFF;
    gap = cyc;
    @(negedge clk);
    send_pkt(4, -1, 1'b0, eop);
    cfg_step = 16'h0000;
    drain("gap_apply", 20);
    @(negedge clk);
    check("gap_apply_cycle", 32'(last_pulse_cyc), 32'(gap + 1));

    // cfg_win_min above cfg_win_max under congestion clamps at cfg_win_max
    cfg_win_max   = 16'h3000;
    cfg_win_min   = 16'h5000;
    cfg_thresh_hi = 12'd0;
    expect_upd(16'h3000, 1'b1);
    drain("min_gt_max_clamp", 3 * PERIOD);
    repeat (2 * PERIOD) @(negedge clk);
    check("min_gt_max_hold", 32'(win_value), 32'h3000);

    // disable mid-packet: win_enable only drops in the idle cycle after EOP
    send_pkt(10, 3, 1'b0, eop);
    check("enable_held_to_eop", 32'(win_enable), 32'h1);
    @(negedge clk);
    check("enable_drops_after_eop", 32'(win_enable), 32'h0);
    expect_upd(16'h3800, 1'b0);
    cfg_win_max = 16'h3800;
    drain("disabled_tracks_wmax", 20);

    // re-enable mid-packet
    cfg_thresh_hi = 12'd4095;
    cfg_win_min   = 16'h0400;
    send_pkt(6, 2, 1'b1, eop);
    check("enable_low_to_eop", 32'(win_enable), 32'h0);
    @(negedge clk);
    check("enable_rises_after_eop", 32'(win_enable), 32'h1);

    // reset in the middle of a packet returns the tracker to IDLE
    word(8'hFF);
    word(8'h00);
    word(8'h00);
    in_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midpkt_reset_value", 32'(win_value), 32'hFFFF);
    check("midpkt_reset_enable", 32'(win_enable), 32'h0);
    expect_upd(16'h3800, 1'b1);
    reset = 1'b0;
    drain("post_reset_apply", 3 * PERIOD);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/recwind_window_ctrl.md
# recwind_window_ctrl

Closed-loop controller that picks the TCP receive-window value used by the receive-window modifier stage. It smooths output-queue occupancy, runs an AIMD step on the window target, and snoops the datapath handshake. New window values are handed to the modifier only between packets, so one packet never sees two values. It sits beside the modifier in the user datapath and is configured through that stage's software registers.

## Interface
- DATA_WIDTH, 64, datapath word width (snooped only)
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width
- OCC_WIDTH, 12, output-queue occupancy width (words)
- SAMPLE_BITS, 10, sample period = 2^SAMPLE_BITS cycles
- EWMA_SHIFT, 3, smoothing weight 1/2^EWMA_SHIFT
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_ctrl  in  CTRL_WIDTH  ctrl of the word entering the modifier
- in_wr  in  1  word valid into the modifier
- in_rdy  in  1  modifier ready; a word is accepted when in_wr && in_rdy
- oq_occupancy  in  OCC_WIDTH  current output-queue fill
- cfg_enable  in  1  controller enable
- cfg_win_max  in  16  upper window bound
- cfg_win_min  in  16  lower window bound
- cfg_step  in  16  additive increase per sample
- cfg_thresh_hi  in  OCC_WIDTH  congestion threshold
- cfg_thresh_lo  in  OCC_WIDTH  relief threshold
- win_value  out  16  window the modifier writes into the TCP header
- win_enable  out  1  modifier rewrites when high
- win_update  out  1  one-cycle pulse when win_value changes

## Operation
- Effective bounds: `wmax = cfg_win_max`. `wmin = min(cfg_win_min, cfg_win_max)`.
- Sample counter: free-running over SAMPLE_BITS bits. `sample` is asserted when the counter equals all-ones, then the counter wraps to 0.
- EWMA accumulator `acc`, width OCC_WIDTH+EWMA_SHIFT, unsigned:
  - on `sample`: `acc <= acc - (acc >> EWMA_SHIFT) + oq_occupancy`
  - smoothed value: `avg = acc >> EWMA_SHIFT`
  - this update can never overflow
- Target update, evaluated in the cycle after `sample` using the new `avg`:
  - if `avg >= cfg_thresh_hi`: `target <= max(target >> 1, wmin)`
  - else if `avg <= cfg_thresh_lo`: `target <= min(target + cfg_step, wmax)`; the sum is computed in 17 bits and saturates
  - otherwise `target` holds
  - if `target` changes, set `pending`
- If `cfg_thresh_lo >= cfg_thresh_hi`, the hi test takes priority.
- Packet tracker FSM, advanced only on accepted words:
  - IDLE: word with ctrl≠0 → HDR; ctrl==0 → BODY
  - HDR: word with ctrl==0 → BODY
  - BODY: word with ctrl≠0 (EOP) → IDLE
- Apply rule: in a cycle where state==IDLE, no word is accepted, and `pending` is set:
  - `win_value <= target`
  - pulse `win_update`
  - clear `pending`
- Same-cycle conflicts:
  - If a target change and an apply coincide, the apply uses the old target and `pending` stays set.
  - If a packet start and an apply coincide, the start wins and the apply waits for the next IDLE gap.
- `cfg_enable=0`:
  - `win_enable=0`, `target` forced to `wmax`, `acc` cleared
  - `pending` is set if `win_value≠wmax`, so `win_value` still tracks `wmax` at the next boundary
- `cfg_enable` going 0→1: `win_enable` rises only at an IDLE apply-eligible cycle, never mid-packet.

## Timing
- Reset values:
  - `win_value=16'hFFFF`, `win_enable=0`, `win_update=0`
  - `acc=0`, counter=0, `target=16'hFFFF`, `pending=0`, FSM=IDLE
- Reset mid-packet: the FSM returns to IDLE. Partial-packet state is discarded and the modifier is reset on the same signal.
- Latency from `sample` to `target`: 1 cycle. From `pending` to `win_update`: ≥1 cycle, unbounded while a packet is in flight.
- All outputs are registered. `win_value` is stable from one `win_update` to the next.

## Structure
- Package `recwind_pkg`:
  - FSM encoding `IDLE`/`HDR`/`BODY`
  - `WIN_W=16`, `WIN_RESET=16'hFFFF`
- Sub-module `recwind_ewma`: counter, `acc`, and `sample`/`avg` outputs. The top level holds the AIMD logic, the FSM and the apply logic.

## Test plan
- Reset, then `cfg_enable=1`, occupancy 0, wmax=0x4000 → at the first IDLE cycle after `sample`, `win_value=0x4000`, one `win_update` pulse, `win_enable=1`.
- Occupancy held at 1000 with hi=800, wmin=0x0400, wmax=0x4000:
  - `avg` converges toward 1000
  - once `avg>=800`, the window halves each sample: 0x2000, 0x1000, 0x0800, 0x0400, then holds at 0x0400
- Occupancy 0, lo=100, step=0x0100, target 0x0400 → target 0x0500, 0x0600, … and saturates at wmax, with no pulse once it is reached.
- Target change while a 10-word packet is streaming → no `win_update` until the EOP word is accepted; the pulse comes in the first following idle cycle.
- Back-to-back packets with zero gap → update deferred; a single idle cycle then applies it. A packet start in the same cycle as an eligible apply defers it again.
- `cfg_win_min=0x5000 > cfg_win_max=0x3000` under congestion → window clamps at 0x3000; `cfg_enable=0` mid-packet → `win_enable` drops only after EOP.
